// File: rtl/program_loader.sv
// Byte-stream instruction loader: packs UART bytes into 16-bit BIP words and writes them to program memory.
// Latency: PM_WE asserts one cycle after the RX_VALID of the low byte.
// Backpressure: none; RX_VALID is ignored outside WAIT_HI/WAIT_LO/WRITE, and START_LOAD is ignored while BUSY.
//
// Ports:
//   CLK, RESET           rising-edge clock, asynchronous active-high reset
//   START_LOAD           one-cycle pulse that begins a load
//   RX_DATA, RX_VALID    received byte and its one-cycle strobe
//   PM_WE/ADDR/WDATA     program memory write port
//   BUSY, CPU_RESET      load in progress (CPU held in reset while loading)
//   LOAD_DONE, LOAD_ERR  sticky status of the current or last load
//   INSTR_COUNT          words written in the current or last load
module program_loader #(
    parameter int ADDR_W     = 11,
    parameter int MAX_OPCODE = 7
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START_LOAD,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              PM_WE,
    output logic [ADDR_W-1:0] PM_ADDR,
    output logic [15:0]       PM_WDATA,
    output logic              BUSY,
    output logic              CPU_RESET,
    output logic              LOAD_DONE,
    output logic              LOAD_ERR,
    output logic [ADDR_W:0]   INSTR_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [4:0]        MAX_OP   = MAX_OPCODE[4:0];
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};

    state_t              state_q, state_d;
    logic [7:0]          hi_q, hi_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            hi_q    <= 8'h00;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // A byte arriving with START_LOAD is deliberately dropped.
                if (START_LOAD) begin
                    state_d = S_WAIT_HI;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    addr_d  = '0;
                end
            end
            S_WAIT_HI: begin
                if (RX_VALID) begin
                    hi_d    = RX_DATA;
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (RX_VALID) begin
                    if (hi_q[7:3] > MAX_OP) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        wdata_d = {hi_q, RX_DATA};
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                cnt_d  = cnt_q + CNT_ONE;
                addr_d = addr_q + ADDR_ONE;   // wraps to 0 after the top address
                // HALT and memory-full win over a byte arriving in this cycle.
                if (wdata_q[15:11] == 5'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (addr_q == ADDR_TOP) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else if (RX_VALID) begin
                    hi_d    = RX_DATA;
                    state_d = S_WAIT_LO;
                end else begin
                    state_d = S_WAIT_HI;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decoded straight from state so the reset drops PM_WE and BUSY asynchronously.
    assign PM_WE       = (state_q == S_WRITE);
    assign BUSY        = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO) || (state_q == S_WRITE);
    assign CPU_RESET   = BUSY;
    assign PM_ADDR     = addr_q;
    assign PM_WDATA    = wdata_q;
    assign LOAD_DONE   = done_q;
    assign LOAD_ERR    = err_q;
    assign INSTR_COUNT = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    // full-size instance
    logic        start, rxv;
    logic [7:0]  rxd;
    logic        we, busy, cpu_rst, done, err;
    logic [10:0] addr;
    logic [15:0] wdata;
    logic [11:0] cnt;
    // ADDR_W=2 instance for the memory-full case
    logic        start_s, rxv_s;
    logic [7:0]  rxd_s;
    logic        we_s, busy_s, cpu_rst_s, done_s, err_s;
    logic [1:0]  addr_s;
    logic [15:0] wdata_s;
    logic [2:0]  cnt_s;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;
    wr_t q_big[$];
    wr_t q_sm[$];

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] word;
    } vec_t;
    vec_t prog[3];

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(11), .MAX_OPCODE(7)) dut (
        .CLK(clk), .RESET(rst), .START_LOAD(start), .RX_DATA(rxd), .RX_VALID(rxv),
        .PM_WE(we), .PM_ADDR(addr), .PM_WDATA(wdata), .BUSY(busy), .CPU_RESET(cpu_rst),
        .LOAD_DONE(done), .LOAD_ERR(err), .INSTR_COUNT(cnt)
    );

    program_loader #(.ADDR_W(2), .MAX_OPCODE(7)) dut_s (
        .CLK(clk), .RESET(rst), .START_LOAD(start_s), .RX_DATA(rxd_s), .RX_VALID(rxv_s),
        .PM_WE(we_s), .PM_ADDR(addr_s), .PM_WDATA(wdata_s), .BUSY(busy_s), .CPU_RESET(cpu_rst_s),
        .LOAD_DONE(done_s), .LOAD_ERR(err_s), .INSTR_COUNT(cnt_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every PM_WE seen must match the oldest pushed expectation.
    task automatic mon();
        wr_t e;
        if (we === 1'b1) begin
            if (q_big.size() == 0) begin
                checks++; failures++;
                $display("FAIL big_unexpected_we actual addr=0x%0h data=0x%0h required no write", addr, wdata);
            end else begin
                e = q_big.pop_front();
                chk("big_wr_addr", 32'(addr), 32'(e.addr));
                chk("big_wr_data", 32'(wdata), 32'(e.data));
            end
        end
        if (we_s === 1'b1) begin
            if (q_sm.size() == 0) begin
                checks++; failures++;
                $display("FAIL sm_unexpected_we actual addr=0x%0h data=0x%0h required no write", addr_s, wdata_s);
            end else begin
                e = q_sm.pop_front();
                chk("sm_wr_addr", 32'(addr_s), 32'(e.addr));
                chk("sm_wr_data", 32'(wdata_s), 32'(e.data));
            end
        end
    endtask

    // One clock: sample outputs on the falling edge, return 1 time unit after the rising edge.
    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sm, input logic [7:0] d);
        if (sm) begin rxd_s = d; rxv_s = 1'b1; end
        else    begin rxd   = d; rxv   = 1'b1; end
        cyc();
        rxv = 1'b0; rxv_s = 1'b0;
    endtask

    task automatic pulse_start(input bit sm);
        if (sm) start_s = 1'b1; else start = 1'b1;
        cyc();
        start = 1'b0; start_s = 1'b0;
    endtask

    task automatic push(input bit sm, input int a, input logic [15:0] d);
        wr_t e;
        e.addr = a; e.data = d;
        if (sm) q_sm.push_back(e); else q_big.push_back(e);
    endtask

    initial begin
        prog[0] = '{hi: 8'h18, lo: 8'h05, word: 16'h1805};
        prog[1] = '{hi: 8'h20, lo: 8'h03, word: 16'h2003};
        prog[2] = '{hi: 8'h00, lo: 8'h00, word: 16'h0000};

        rst = 1'b1;
        start = 1'b0; rxv = 1'b0; rxd = 8'h00;
        start_s = 1'b0; rxv_s = 1'b0; rxd_s = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ---- async reset in the middle of a cycle ----
        pulse_start(1'b0);
        chk("busy_after_start", 32'(busy), 1);
        chk("cpurst_after_start", 32'(cpu_rst), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cpurst", 32'(cpu_rst), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_sm_busy", 32'(busy_s), 0);
        chk("rst_sm_cnt", 32'(cnt_s), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---- test 1: table-driven three-word program ending in HALT ----
        pulse_start(1'b0);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, prog[i].hi);
            cyc();
            send(1'b0, prog[i].lo);
            push(1'b0, i, prog[i].word);
            cyc();
        end
        chk("t1_done", 32'(done), 1);
        chk("t1_err", 32'(err), 0);
        chk("t1_cnt", 32'(cnt), 3);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_cpurst", 32'(cpu_rst), 0);

        // ---- test 2: invalid opcode aborts ----
        pulse_start(1'b0);
        chk("t2_done_cleared", 32'(done), 0);
        chk("t2_cnt_cleared", 32'(cnt), 0);
        send(1'b0, 8'h08); send(1'b0, 8'h10); push(1'b0, 0, 16'h0810);
        cyc();
        send(1'b0, 8'h40); send(1'b0, 8'h00);
        chk("t2_err", 32'(err), 1);
        chk("t2_done", 32'(done), 0);
        chk("t2_busy", 32'(busy), 0);
        chk("t2_cnt", 32'(cnt), 1);
        repeat (3) cyc();

        // ---- test 3: memory full on the 4-word instance ----
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 8'h28); send(1'b1, 8'h01); push(1'b1, i, 16'h2801);
            cyc();
        end
        chk("t3_err", 32'(err_s), 1);
        chk("t3_done", 32'(done_s), 0);
        chk("t3_cnt", 32'(cnt_s), 4);
        chk("t3_busy", 32'(busy_s), 0);
        chk("t3_addr_wrap", 32'(addr_s), 0);
        send(1'b1, 8'h28); send(1'b1, 8'h01);
        repeat (2) cyc();
        chk("t3_cnt_after", 32'(cnt_s), 4);

        // ---- test 4: back-to-back, next high byte lands in WRITE ----
        pulse_start(1'b0);
        send(1'b0, 8'h18); send(1'b0, 8'h05); push(1'b0, 0, 16'h1805);
        chk("t4_we_in_write", 32'(we), 1);
        send(1'b0, 8'h20);                  // arrives during WRITE
        send(1'b0, 8'h03); push(1'b0, 1, 16'h2003);
        send(1'b0, 8'h00);                  // also during WRITE
        send(1'b0, 8'h00); push(1'b0, 2, 16'h0000);
        send(1'b0, 8'h18);                  // during HALT's WRITE: dropped
        chk("t4_done", 32'(done), 1);
        chk("t4_cnt", 32'(cnt), 3);
        chk("t4_addr", 32'(addr), 3);
        send(1'b0, 8'h05);                  // ignored in DONE
        chk("t4_done_busy", 32'(busy), 0);

        // ---- test 5: START with a byte in the same cycle; START in WAIT_LO ----
        rxd = 8'hAA; rxv = 1'b1;
        pulse_start(1'b0);
        rxv = 1'b0;
        send(1'b0, 8'h10); send(1'b0, 8'h07); push(1'b0, 0, 16'h1007);
        cyc();
        send(1'b0, 8'h18);
        pulse_start(1'b0);                  // in WAIT_LO: no effect
        chk("t5_busy", 32'(busy), 1);
        chk("t5_addr", 32'(addr), 1);
        send(1'b0, 8'h01); push(1'b0, 1, 16'h1801);
        cyc();
        chk("t5_cnt", 32'(cnt), 2);

        // ---- test 6: reset during WRITE ----
        send(1'b0, 8'h20); send(1'b0, 8'h03);
        chk("t6_we_before", 32'(we), 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_we_dropped", 32'(we), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t6_cnt", 32'(cnt), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_err", 32'(err), 0);
        chk("t6_busy", 32'(busy), 0);
        // bytes in IDLE are ignored
        send(1'b0, 8'h18); send(1'b0, 8'h05);
        repeat (2) cyc();
        chk("t6_idle_busy", 32'(busy), 0);
        chk("t6_idle_cnt", 32'(cnt), 0);

        chk("big_pending", 32'(q_big.size()), 0);
        chk("sm_pending", 32'(q_sm.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the BIP instruction path. The instruction decoder consumes 16-bit instruction words ({OPCODE[4:0], OPERAND[10:0]}); this block produces them.
- It assembles instructions from a byte stream (UART RX output), checks the opcode, and writes each word into program memory at consecutive addresses.
- It holds the CPU in reset while a load is in progress.
- It sits between the UART receiver and the program memory write port.

Parameters:
- ADDR_W, 11, program memory address width; depth is 2^ADDR_W words.
- MAX_OPCODE, 7, highest legal opcode (HALT=0 … SUBI=7).

Ports:
- CLK  input  1  system clock; all logic is rising-edge.
- RESET  input  1  asynchronous, active-high reset.
- START_LOAD  input  1  one-cycle pulse that begins a load.
- RX_DATA  input  8  received byte.
- RX_VALID  input  1  one-cycle strobe; RX_DATA is valid in that cycle.
- PM_WE  output  1  program memory write enable (one-cycle pulse).
- PM_ADDR  output  ADDR_W  program memory write address.
- PM_WDATA  output  16  instruction word to write.
- BUSY  output  1  high while a load is in progress.
- CPU_RESET  output  1  holds the BIP CPU in reset; equals BUSY.
- LOAD_DONE  output  1  sticky: load ended on HALT.
- LOAD_ERR  output  1  sticky: load aborted.
- INSTR_COUNT  output  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Reset (async, immediate): state IDLE. PM_WE=0, PM_ADDR=0, PM_WDATA=0, BUSY=0, CPU_RESET=0, LOAD_DONE=0, LOAD_ERR=0, INSTR_COUNT=0.
- Byte format: high byte first = {OPCODE[4:0], OPERAND[10:8]}; low byte = OPERAND[7:0].
- States: IDLE, WAIT_HI, WAIT_LO, WRITE, DONE, ERROR.
- IDLE, DONE, ERROR: START_LOAD → WAIT_HI. On that transition:
  - clear LOAD_DONE, LOAD_ERR, INSTR_COUNT and PM_ADDR;
  - set BUSY=1.
  - RX_VALID in these states is ignored. If RX_VALID and START_LOAD are high in the same cycle, the start is taken and the byte is dropped.
- WAIT_HI: RX_VALID → latch high byte, go to WAIT_LO.
- WAIT_LO: RX_VALID → form the word.
  - If opcode > MAX_OPCODE → ERROR. No write; LOAD_ERR=1; BUSY=0.
  - Otherwise register PM_WDATA and go to WRITE.
- WRITE lasts exactly one cycle. PM_WE=1 with PM_ADDR/PM_WDATA stable. Latency is one cycle from the low-byte RX_VALID to PM_WE.
- Leaving WRITE (next cycle): INSTR_COUNT+1, PM_ADDR+1. Then:
  - opcode==0 (HALT) → DONE: LOAD_DONE=1, BUSY=0.
  - else PM_ADDR was 2^ADDR_W−1 (memory full, no HALT) → ERROR: LOAD_ERR=1, BUSY=0. PM_ADDR wraps to 0 but no further write occurs.
  - else → WAIT_HI.
- RX_VALID during WRITE is accepted as the next high byte; the state goes to WAIT_LO instead of WAIT_HI, with the same HALT/full checks taking priority. If HALT or full applies, that byte is dropped.
- START_LOAD while BUSY is ignored. A load is aborted only by RESET.
- RESET mid-load: aborts immediately. Any in-flight PM_WE drops asynchronously and no partial word is written.
- PM_WE is never high outside WRITE.
- INSTR_COUNT saturates naturally at 2^ADDR_W; its width prevents overflow.
- Timing relations:
  - CPU_RESET deasserts in the same cycle LOAD_DONE or LOAD_ERR asserts.
  - LOAD_DONE and LOAD_ERR are mutually exclusive.

Test Plan:
1. RESET high mid-cycle → all outputs 0 asynchronously; START_LOAD, then bytes 0x18,0x05 (LDI 5), 0x20,0x03 (ADD 3), 0x00,0x00 (HALT) → three PM_WE pulses: addr0=0x1805, addr1=0x2003, addr2=0x0000. Then LOAD_DONE=1, INSTR_COUNT=3, BUSY=CPU_RESET=0.
2. Invalid opcode: START_LOAD, bytes 0x08,0x10 (STO 0x10), then 0x40,0x00 (opcode 8) → one write (addr0=0x0810). LOAD_ERR=1, INSTR_COUNT=1, no second PM_WE.
3. Memory full: ADDR_W=2, four non-HALT instructions (0x28,0x01 ×4) → PM_WE at addresses 0..3. After the fourth, LOAD_ERR=1, INSTR_COUNT=4; a fifth byte pair produces no write.
4. Back-to-back: the next high byte's RX_VALID lands exactly in the WRITE cycle → it is accepted. The following low byte produces the correct next word at addr+1.
5. Ignore rules:
   - RX_VALID in IDLE → no state change.
   - START_LOAD with RX_VALID (0xAA) in the same cycle → 0xAA dropped; the first stored high byte is the next one.
   - START_LOAD while in WAIT_LO → no effect.
6. RESET asserted one cycle after a low byte (during WRITE) → PM_WE drops immediately. After release: IDLE, INSTR_COUNT=0, LOAD_DONE=LOAD_ERR=0.
